// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 init sequencer and its table ROM.
package ov7670_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWRUP,
        S_FETCH,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DELAY,
        S_NEXT_CAM,
        S_DONE,
        S_ERROR,
        S_H_ISSUE,
        S_H_WAIT_HI,
        S_H_WAIT_LO
    } seq_state_t;

    localparam logic [7:0]  OV7670_WR_ID = 8'h42;
    localparam logic [7:0]  OV7670_RD_ID = 8'h43;

    localparam logic [15:0] TBL_END   = 16'hFFFF;
    localparam logic [7:0]  TBL_DELAY = 8'hF0;

    localparam int unsigned ROM_DEPTH = 8;
    localparam int unsigned IDX_W     = $clog2(ROM_DEPTH);

    // True when a table entry is a millisecond delay rather than a register write.
    function automatic logic is_delay_entry(input logic [15:0] entry);
        return (entry[15:8] == TBL_DELAY) && (entry != TBL_END);
    endfunction

endpackage

// File: rtl/ov7670_init_rom.sv
// Sensor configuration table: {addr, val} writes, F0nn delays, FFFF terminator.
module ov7670_init_rom
    import ov7670_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [15:0]      entry
);

    // Combinational lookup so the sequencer can decode an entry in one cycle.
    always_comb begin
        entry = TBL_END;
        case (idx)
            IDX_W'(0): entry = 16'h1280;
            IDX_W'(1): entry = 16'hF00A;
            IDX_W'(2): entry = 16'h1204;
            IDX_W'(3): entry = 16'h40D0;
            IDX_W'(4): entry = 16'hF003;
            IDX_W'(5): entry = 16'h3A04;
            IDX_W'(6): entry = TBL_END;
            default:   entry = TBL_END;
        endcase
    end

endmodule

// File: rtl/ov7670_sccb_seq.sv
// Walks the init table for each camera over the shared SCCB master, then
// serves PS register accesses so host and init traffic never overlap.
module ov7670_sccb_seq
    import ov7670_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ   = 125_000_000,
    parameter int unsigned CAM_COUNT    = 2,
    parameter int unsigned POWERUP_MS   = 10,
    parameter int unsigned BUSY_TIMEOUT = 2**20,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic        sysclk,
    input  logic        n_rst,
    input  logic        start,
    output logic        sccb_req,
    output logic [23:0] sccb_send_data,
    input  logic        sccb_busy,
    input  logic [7:0]  sccb_recv_data,
    output logic        cam_sel,
    input  logic        host_req,
    input  logic        host_cam,
    input  logic [23:0] host_data,
    output logic        host_busy,
    output logic [7:0]  host_recv,
    output logic        init_done,
    output logic        init_err
);

    localparam int unsigned TICK_CYC    = CLOCK_FREQ / 1000;
    localparam logic [31:0] PWRUP_CYC   = 32'(POWERUP_MS * TICK_CYC);
    localparam logic [31:0] TIMEOUT_CYC = 32'(BUSY_TIMEOUT);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             sccb_req_q, sccb_req_d;
    logic [23:0]      send_q, send_d;
    logic             cam_sel_q, cam_sel_d;
    logic             host_busy_q, host_busy_d;
    logic [7:0]       host_recv_q, host_recv_d;
    logic             init_done_q, init_done_d;
    logic             init_err_q, init_err_d;

    logic [15:0]      rom_entry;
    logic [31:0]      delay_cyc;
    logic             idx_last;
    logic             more_cams;
    logic             wait_expired;

    ov7670_init_rom u_rom (
        .idx   (idx_q),
        .entry (rom_entry)
    );

    // The last ROM slot doubles as an implicit terminator: stepping past it ends the camera.
    assign idx_last     = (idx_q == IDX_W'(ROM_DEPTH - 1));
    assign delay_cyc    = 32'(rom_entry[7:0]) * 32'(TICK_CYC);
    assign more_cams    = (32'(cam_sel_q) < (CAM_COUNT - 1));
    assign wait_expired = ((cnt_q + 32'd1) >= TIMEOUT_CYC);

    // State and all registered outputs; synchronous reset aborts any transaction at once.
    always_ff @(posedge sysclk) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            sccb_req_q  <= 1'b0;
            send_q      <= '0;
            cam_sel_q   <= 1'b0;
            host_busy_q <= 1'b1;
            host_recv_q <= '0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            sccb_req_q  <= sccb_req_d;
            send_q      <= send_d;
            cam_sel_q   <= cam_sel_d;
            host_busy_q <= host_busy_d;
            host_recv_q <= host_recv_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
        end
    end

    // Next-state decision; start outranks a simultaneous host request in DONE/ERROR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (AUTO_START || start) state_d = S_PWRUP;
            S_PWRUP:     if ((cnt_q + 32'd1) >= PWRUP_CYC) state_d = S_FETCH;
            S_FETCH: begin
                if (rom_entry == TBL_END)           state_d = S_NEXT_CAM;
                else if (is_delay_entry(rom_entry)) state_d = S_DELAY;
                else                                state_d = S_ISSUE;
            end
            S_ISSUE:     state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (sccb_busy)         state_d = S_WAIT_LO;
                else if (wait_expired) state_d = S_ERROR;
            end
            S_WAIT_LO: begin
                if (!sccb_busy)        state_d = idx_last ? S_NEXT_CAM : S_FETCH;
                else if (wait_expired) state_d = S_ERROR;
            end
            S_DELAY: begin
                if ((cnt_q + 32'd1) >= delay_cyc) state_d = idx_last ? S_NEXT_CAM : S_FETCH;
            end
            S_NEXT_CAM:  state_d = more_cams ? S_PWRUP : S_DONE;
            S_DONE, S_ERROR: begin
                if (start)         state_d = S_PWRUP;
                else if (host_req) state_d = S_H_ISSUE;
            end
            S_H_ISSUE:   state_d = S_H_WAIT_HI;
            S_H_WAIT_HI: begin
                if (sccb_busy)         state_d = S_H_WAIT_LO;
                else if (wait_expired) state_d = S_ERROR;
            end
            S_H_WAIT_LO: begin
                if (!sccb_busy)        state_d = init_err_q ? S_ERROR : S_DONE;
                else if (wait_expired) state_d = S_ERROR;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    // Datapath updates driven by the current state and the transition being taken.
    always_comb begin
        idx_d       = idx_q;
        cnt_d       = (state_d == state_q) ? (cnt_q + 32'd1) : 32'd0;
        sccb_req_d  = 1'b0;
        send_d      = send_q;
        cam_sel_d   = cam_sel_q;
        host_recv_d = host_recv_q;
        init_done_d = init_done_q;
        init_err_d  = init_err_q;
        host_busy_d = !((state_d == S_DONE) || (state_d == S_ERROR));
        case (state_q)
            S_IDLE: begin
                if (state_d == S_PWRUP) begin
                    idx_d     = '0;
                    cam_sel_d = 1'b0;
                end
            end
            S_ISSUE: begin
                sccb_req_d = 1'b1;
                send_d     = {OV7670_WR_ID, rom_entry};
            end
            S_WAIT_LO, S_DELAY: begin
                if ((state_d == S_FETCH) || (state_d == S_NEXT_CAM)) begin
                    idx_d = idx_last ? '0 : (idx_q + IDX_W'(1));
                end
            end
            S_NEXT_CAM: begin
                if (more_cams) begin
                    cam_sel_d = cam_sel_q + 1'b1;
                    idx_d     = '0;
                end else begin
                    init_done_d = 1'b1;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    idx_d       = '0;
                    cam_sel_d   = 1'b0;
                    init_done_d = 1'b0;
                    init_err_d  = 1'b0;
                end else if (host_req) begin
                    cam_sel_d = host_cam;
                    send_d    = host_data;
                end
            end
            S_H_ISSUE:   sccb_req_d = 1'b1;
            S_H_WAIT_LO: if (!sccb_busy) host_recv_d = sccb_recv_data;
            default:     ;
        endcase
        if ((state_d == S_ERROR) && (state_q != S_ERROR)) init_err_d = 1'b1;
    end

    assign sccb_req       = sccb_req_q;
    assign sccb_send_data = send_q;
    assign cam_sel        = cam_sel_q;
    assign host_busy      = host_busy_q;
    assign host_recv      = host_recv_q;
    assign init_done      = init_done_q;
    assign init_err       = init_err_q;

endmodule

// File: tb/tb_ov7670_sccb_seq.sv
// Scoreboard bench for ov7670_sccb_seq with a behavioural SCCB master model.
module tb_ov7670_sccb_seq;

    localparam int unsigned BT       = 200;
    localparam int          BUSY_LEN = 20;

    logic        sysclk = 1'b0;
    logic        n_rst;
    logic        start;
    logic        sccb_req;
    logic [23:0] sccb_send_data;
    logic        sccb_busy;
    logic [7:0]  sccb_recv_data;
    logic        cam_sel;
    logic        host_req;
    logic        host_cam;
    logic [23:0] host_data;
    logic        host_busy;
    logic [7:0]  host_recv;
    logic        init_done;
    logic        init_err;

    int          checkCount = 0;
    int          failCount  = 0;
    int          cyc        = 0;
    int          busyLeft   = 0;
    logic        modelMute  = 1'b0;
    logic [24:0] expQ[$];
    int          reqTimes[$];
    logic [15:0] initWrites [4] = '{16'h1280, 16'h1204, 16'h40D0, 16'h3A04};

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    ov7670_sccb_seq #(
        .CLOCK_FREQ   (10_000),
        .CAM_COUNT    (2),
        .POWERUP_MS   (1),
        .BUSY_TIMEOUT (BT),
        .AUTO_START   (1'b1)
    ) dut (
        .sysclk         (sysclk),
        .n_rst          (n_rst),
        .start          (start),
        .sccb_req       (sccb_req),
        .sccb_send_data (sccb_send_data),
        .sccb_busy      (sccb_busy),
        .sccb_recv_data (sccb_recv_data),
        .cam_sel        (cam_sel),
        .host_req       (host_req),
        .host_cam       (host_cam),
        .host_data      (host_data),
        .host_busy      (host_busy),
        .host_recv      (host_recv),
        .init_done      (init_done),
        .init_err       (init_err)
    );

    // SCCB master model: busy one cycle after a request, held for BUSY_LEN cycles; PID read returns 0x76.
    always @(posedge sysclk) begin
        if (!n_rst) begin
            busyLeft       <= 0;
            sccb_recv_data <= 8'h00;
        end else if (sccb_req && !modelMute) begin
            busyLeft       <= BUSY_LEN;
            sccb_recv_data <= (sccb_send_data[23:8] == 16'h430A) ? 8'h76 : (sccb_send_data[7:0] ^ 8'hA5);
        end else if (busyLeft != 0) begin
            busyLeft <= busyLeft - 1;
        end
    end
    assign sccb_busy = (busyLeft != 0);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, observed, expected);
        end
    endtask

    // Every request pulse is popped against the next expected {cam_sel, send_data}.
    always @(negedge sysclk) begin
        if (n_rst && sccb_req) begin
            reqTimes.push_back(cyc);
            if (expQ.size() == 0) begin
                checkOutput("sb_unexpected_req", {7'd0, cam_sel, sccb_send_data}, 32'd0);
            end else begin
                logic [24:0] e;
                e = expQ.pop_front();
                checkOutput("sb_req", {7'd0, cam_sel, sccb_send_data}, {7'd0, e});
            end
        end
    end

    task automatic pushInit();
        for (int c = 0; c < 2; c++) begin
            for (int w = 0; w < 4; w++) begin
                expQ.push_back({c[0], 8'h42, initWrites[w]});
            end
        end
    endtask

    // Drives one-cycle pulses on start/host_req starting at the current negedge.
    task automatic applyStimulus(input logic s, input logic h, input logic cam, input logic [23:0] d);
        start     = s;
        host_req  = h;
        host_cam  = cam;
        host_data = d;
        @(negedge sysclk);
        start    = 1'b0;
        host_req = 1'b0;
    endtask

    function automatic logic flagOf(input int which);
        case (which)
            0:       return init_done;
            1:       return !host_busy;
            2:       return init_err;
            3:       return (expQ.size() == 7);
            default: return sccb_busy;
        endcase
    endfunction

    task automatic waitFlag(input string tag, input int which, input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge sysclk);
            if (flagOf(which)) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_reached"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_sccb_req"},  {31'd0, sccb_req},  32'd0);
        checkOutput({pfx, "_send_data"}, {8'd0, sccb_send_data}, 32'd0);
        checkOutput({pfx, "_cam_sel"},   {31'd0, cam_sel},   32'd0);
        checkOutput({pfx, "_host_busy"}, {31'd0, host_busy}, 32'd1);
        checkOutput({pfx, "_host_recv"}, {24'd0, host_recv}, 32'd0);
        checkOutput({pfx, "_init_done"}, {31'd0, init_done}, 32'd0);
        checkOutput({pfx, "_init_err"},  {31'd0, init_err},  32'd0);
    endtask

    initial begin
        int g01, g12, g23, g45, tErr, t0;
        n_rst     = 1'b0;
        start     = 1'b0;
        host_req  = 1'b0;
        host_cam  = 1'b0;
        host_data = 24'h0;
        repeat (3) @(negedge sysclk);
        checkResetValues("rst");

        // Full init of both cameras, with a host request dropped mid-way.
        pushInit();
        reqTimes.delete();
        n_rst = 1'b1;
        repeat (40) @(negedge sysclk);
        applyStimulus(1'b0, 1'b1, 1'b1, 24'h421122);
        checkOutput("busy_during_init", {31'd0, host_busy}, 32'd1);
        waitFlag("init1_done", 0, 3000);
        checkOutput("init1_err", {31'd0, init_err}, 32'd0);
        checkOutput("init1_host_busy", {31'd0, host_busy}, 32'd0);
        checkOutput("init1_sb_left", 32'(expQ.size()), 32'd0);
        checkOutput("init1_req_count", 32'(reqTimes.size()), 32'd8);
        if (reqTimes.size() == 8) begin
            g01 = reqTimes[1] - reqTimes[0];
            g12 = reqTimes[2] - reqTimes[1];
            g23 = reqTimes[3] - reqTimes[2];
            g45 = reqTimes[5] - reqTimes[4];
            // Back-to-back writes: 1 cycle to busy, 20 busy, then WAIT_LO exit, FETCH, ISSUE.
            checkOutput("gap_normal", 32'(g12), 32'd24);
            // A delay entry adds its own FETCH cycle plus nn ticks of 10 cycles.
            checkOutput("gap_delay_10ms", 32'(g01 - g12), 32'd101);
            checkOutput("gap_delay_3ms", 32'(g23 - g12), 32'd31);
            checkOutput("gap_cam1_repeat", 32'(g45), 32'(g01));
        end

        // Host write once init is done.
        expQ.push_back({1'b0, 24'h421502});
        applyStimulus(1'b0, 1'b1, 1'b0, 24'h421502);
        checkOutput("host_busy_rise", {31'd0, host_busy}, 32'd1);
        waitFlag("host_wr_idle", 1, 200);
        checkOutput("host_wr_recv", {24'd0, host_recv}, 32'hA7);
        checkOutput("host_wr_sb_left", 32'(expQ.size()), 32'd0);
        checkOutput("host_wr_done_kept", {31'd0, init_done}, 32'd1);

        // start beats a simultaneous host request, then reset lands during WAIT_LO.
        pushInit();
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h42AABB);
        checkOutput("restart_done_clr", {31'd0, init_done}, 32'd0);
        checkOutput("restart_host_busy", {31'd0, host_busy}, 32'd1);
        waitFlag("restart_first_req", 3, 200);
        waitFlag("restart_busy", 4, 50);
        repeat (3) @(negedge sysclk);
        n_rst = 1'b0;
        @(negedge sysclk);
        checkResetValues("midrst");
        expQ.delete();
        reqTimes.delete();
        @(negedge sysclk);
        pushInit();
        n_rst = 1'b1;
        waitFlag("init2_done", 0, 3000);
        checkOutput("init2_sb_left", 32'(expQ.size()), 32'd0);
        checkOutput("init2_req_count", 32'(reqTimes.size()), 32'd8);

        // Busy never rises: timeout, then a host read served from ERROR.
        modelMute = 1'b1;
        reqTimes.delete();
        expQ.push_back({1'b0, 24'h421280});
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h0);
        waitFlag("timeout_err", 2, 2000);
        tErr = cyc;
        t0   = (reqTimes.size() > 0) ? reqTimes[0] : 0;
        checkOutput("timeout_req_count", 32'(reqTimes.size()), 32'd1);
        checkOutput("timeout_cycles", 32'(tErr - t0), 32'(BT));
        checkOutput("timeout_done", {31'd0, init_done}, 32'd0);
        checkOutput("timeout_host_busy", {31'd0, host_busy}, 32'd0);
        modelMute = 1'b0;
        expQ.push_back({1'b1, 24'h430A00});
        applyStimulus(1'b0, 1'b1, 1'b1, 24'h430A00);
        checkOutput("err_host_busy_rise", {31'd0, host_busy}, 32'd1);
        waitFlag("err_host_idle", 1, 200);
        checkOutput("err_host_recv", {24'd0, host_recv}, 32'h76);
        checkOutput("err_cam_sel", {31'd0, cam_sel}, 32'd1);
        checkOutput("err_sticky", {31'd0, init_err}, 32'd1);
        checkOutput("err_sb_left", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
